// File: rtl/fp_sqrt_sequencer.sv
// fp_sqrt_sequencer: start/done sequencer driving the register file and ALU through Newton square-root iterations.
// Optional macro FP_SEQ_ALU_WAIT_EN: ALU-issuing states hold until alu_done, with WE following alu_done.
module fp_sqrt_sequencer #(
  parameter int ADDR_W   = 3,
  parameter int ITER_W   = 4,
  parameter int MAX_ITER = 10,
  parameter int A_ZERO   = 0,
  parameter int A_N      = 1,
  parameter int A_X      = 2,
  parameter int A_ROOT   = 3,
  parameter int A_TEMP   = 4,
  parameter int A_TWO    = 5,
  parameter int A_EPS    = 6,
  parameter int A_OUT    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              n_zero,
  input  logic              n_neg,
  input  logic              temp_neg,
  input  logic              alu_done,
  output logic              IE,
  output logic              WE,
  output logic              OE,
  output logic [ADDR_W-1:0] ADDR_WR,
  output logic [ADDR_W-1:0] ADDR_RDA,
  output logic [ADDR_W-1:0] ADDR_RDB,
  output logic [1:0]        ALU_Op,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD_N | latch external n into the register file
  // CHECK  | classify n: negative, zero or normal
  // ZERO   | root = n (sqrt of +-0)
  // INIT_X | x = n, iteration count cleared
  // DIV    | root = n / x
  // ADD    | root = root + x
  // HALF   | root = root / 2
  // SUB    | temp = root - x
  // ABS    | temp = |temp|
  // CMP    | temp = temp - eps
  // TEST   | converged if temp negative, else count and iterate
  // UPD_X  | x = root
  // DONE   | result presented; wait for start to drop
  typedef enum logic [3:0] {
    IDLE, LOAD_N, CHECK, ZERO, INIT_X, DIV, ADD, HALF, SUB, ABS, CMP, TEST, UPD_X, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] AZ = ADDR_W'(A_ZERO);
  localparam logic [ADDR_W-1:0] AN = ADDR_W'(A_N);
  localparam logic [ADDR_W-1:0] AX = ADDR_W'(A_X);
  localparam logic [ADDR_W-1:0] AR = ADDR_W'(A_ROOT);
  localparam logic [ADDR_W-1:0] AT = ADDR_W'(A_TEMP);
  localparam logic [ADDR_W-1:0] A2 = ADDR_W'(A_TWO);
  localparam logic [ADDR_W-1:0] AE = ADDR_W'(A_EPS);
  localparam logic [ADDR_W-1:0] AO = ADDR_W'(A_OUT);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] ITER_SAT  = ITER_W'(MAX_ITER);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  state_t state;
  logic   alu_go;

`ifdef FP_SEQ_ALU_WAIT_EN
  assign alu_go = alu_done;
`else
  logic unused_alu_done;
  assign unused_alu_done = alu_done;
  assign alu_go          = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          err     <= 1'b0;
          timeout <= 1'b0;
          state   <= LOAD_N;
        end
        LOAD_N: state <= CHECK;
        CHECK: begin
          if (n_neg) begin
            err   <= 1'b1;
            state <= DONE;
          end else if (n_zero) begin
            state <= ZERO;
          end else begin
            state <= INIT_X;
          end
        end
        ZERO:   if (alu_go) state <= DONE;
        INIT_X: begin
          iter_cnt <= '0;
          if (alu_go) state <= DIV;
        end
        DIV:    if (alu_go) state <= ADD;
        ADD:    if (alu_go) state <= HALF;
        HALF:   if (alu_go) state <= SUB;
        SUB:    if (alu_go) state <= ABS;
        ABS:    if (alu_go) state <= CMP;
        CMP:    if (alu_go) state <= TEST;
        TEST: begin
          if (temp_neg) begin
            state <= DONE;
          end else begin
            if (iter_cnt != ITER_SAT) iter_cnt <= iter_cnt + 1'b1;
            if (iter_cnt >= ITER_LAST) begin
              timeout <= 1'b1;
              state   <= DONE;
            end else begin
              state <= UPD_X;
            end
          end
        end
        UPD_X:  if (alu_go) state <= DIV;
        DONE:   if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; ALU-issuing states write only when the ALU result is valid.
  always_comb begin
    IE       = 1'b0;
    WE       = 1'b0;
    OE       = 1'b0;
    ADDR_WR  = '0;
    ADDR_RDA = '0;
    ADDR_RDB = '0;
    ALU_Op   = OP_ADD;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD_N: begin
        busy = 1'b1; IE = 1'b1; WE = 1'b1; ADDR_WR = AN;
      end
      CHECK: begin
        busy = 1'b1; ADDR_RDA = AN;
      end
      ZERO: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AR; ADDR_RDA = AN; ADDR_RDB = AZ; ALU_Op = OP_ADD;
      end
      INIT_X: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AX; ADDR_RDA = AN; ADDR_RDB = AZ; ALU_Op = OP_ADD;
      end
      DIV: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AR; ADDR_RDA = AN; ADDR_RDB = AX; ALU_Op = OP_DIV;
      end
      ADD: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AR; ADDR_RDA = AR; ADDR_RDB = AX; ALU_Op = OP_ADD;
      end
      HALF: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AR; ADDR_RDA = AR; ADDR_RDB = A2; ALU_Op = OP_DIV;
      end
      SUB: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AT; ADDR_RDA = AR; ADDR_RDB = AX; ALU_Op = OP_SUB;
      end
      ABS: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AT; ADDR_RDA = AT; ADDR_RDB = AZ; ALU_Op = OP_ABS;
      end
      CMP: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AT; ADDR_RDA = AT; ADDR_RDB = AE; ALU_Op = OP_SUB;
      end
      TEST: begin
        busy = 1'b1; ADDR_RDA = AT;
      end
      UPD_X: begin
        busy = 1'b1; WE = alu_go; ADDR_WR = AX; ADDR_RDA = AR; ADDR_RDB = AZ; ALU_Op = OP_ADD;
      end
      DONE: begin
        done = 1'b1; OE = 1'b1; ADDR_RDA = AR; ADDR_WR = AO;
      end
      default: ;
    endcase
  end

endmodule
